// File: rtl/autoconfig_host_if.sv
// autoconfig_host_if: simplified 68000 bus between the AUTOCONFIG host and the board chain
interface autoconfig_host_if;
  logic [7:0] ADDRESS_HIGH;
  logic [6:0] ADDRESS_LOW;
  logic BUS_AS;
  logic BUS_UDS;
  logic BUS_LDS;
  logic BUS_RW;
  logic DTACK;
  logic [3:0] DATA_IN;
  logic [3:0] DATA_OUT;
  logic DATA_OE;
  modport master (
    output ADDRESS_HIGH, ADDRESS_LOW, BUS_AS, BUS_UDS, BUS_LDS, BUS_RW, DATA_OUT, DATA_OE,
    input DTACK, DATA_IN
  );
  modport slave (
    input ADDRESS_HIGH, ADDRESS_LOW, BUS_AS, BUS_UDS, BUS_LDS, BUS_RW, DATA_OUT, DATA_OE,
    output DTACK, DATA_IN
  );
endinterface

// File: rtl/autoconfig_host.sv
// autoconfig_host: Zorro II AUTOCONFIG initiator that walks the $E80000 chain and assigns base addresses
module autoconfig_host #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_BOARDS = 8,
  parameter logic [7:0] BASE_FIRST = 8'h20,
  parameter logic [8:0] BASE_LIMIT = 9'h0A0
) (
  input  logic MB_CLK,
  input  logic RESET,
  autoconfig_host_if.master bus,
  input  logic START,
  output logic BUSY,
  output logic DONE,
  output logic TIMEOUT,
  output logic BOARD_VALID,
  output logic [7:0] BOARD_BASE,
  output logic [2:0] BOARD_SIZE,
  output logic [7:0] BOARD_PRODUCT,
  output logic BOARD_SHUTUP,
  output logic [3:0] BOARD_COUNT
);
  typedef enum logic [3:0] {IDLE, RD_T0, RD_T1, RD_P0, RD_P1, ALLOC, WR_LO, WR_HI, WR_SHUT, REPORT, FINISH} seq_t;
  typedef enum logic [1:0] {B_IDLE, SETUP, STROBE, RECOV} bus_t;
  seq_t st;
  bus_t ph;
  logic [15:0] tcnt;
  logic tmo, shut, is_wr, is_bus, fits;
  logic [7:0] typ, prod, base;
  logic [8:0] nxt, n, aligned;
  logic [6:0] idx;
  logic [3:0] wdat;
  assign bus.BUS_LDS = 1'b1;
  // register index and write data implied by the current sequencer step
  always_comb begin
    is_wr = st inside {WR_LO, WR_HI, WR_SHUT};
    is_bus = is_wr || st inside {RD_T0, RD_T1, RD_P0, RD_P1};
    idx = st == RD_T1 ? 7'h01 : st == RD_P0 ? 7'h02 : st == RD_P1 ? 7'h03 :
          st == WR_LO ? 7'h25 : st == WR_HI ? 7'h24 : st == WR_SHUT ? 7'h26 : 7'h00;
    wdat = st == WR_LO ? base[3:0] : st == WR_HI ? base[7:4] : 4'h0;
  end
  // size code c covers 64K << (c-1), code 0 is 8M; alignment counts from the window start so 4M boards land at $200000/$600000
  always_comb begin
    n = typ[2:0] == 3'd0 ? 9'd128 : 9'd1 << (typ[2:0] - 3'd1);
    aligned = {1'b0, BASE_FIRST} + ((nxt - {1'b0, BASE_FIRST} + n - 9'd1) & ~(n - 9'd1));
    fits = aligned + n <= BASE_LIMIT;
  end
  // bus engine and board sequencer, all outputs registered
  always_ff @(posedge MB_CLK or negedge RESET)
    if (!RESET) begin
      st <= IDLE;
      ph <= B_IDLE;
      tcnt <= '0;
      tmo <= 1'b0;
      shut <= 1'b0;
      typ <= '0;
      prod <= '0;
      base <= '0;
      nxt <= '0;
      bus.ADDRESS_HIGH <= '0;
      bus.ADDRESS_LOW <= '0;
      bus.BUS_AS <= 1'b1;
      bus.BUS_UDS <= 1'b1;
      bus.BUS_RW <= 1'b1;
      bus.DATA_OUT <= '0;
      bus.DATA_OE <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      TIMEOUT <= 1'b0;
      BOARD_VALID <= 1'b0;
      BOARD_BASE <= '0;
      BOARD_SIZE <= '0;
      BOARD_PRODUCT <= '0;
      BOARD_SHUTUP <= 1'b0;
      BOARD_COUNT <= '0;
    end else begin
      DONE <= 1'b0;
      BOARD_VALID <= 1'b0;
      case (ph)
        B_IDLE: if (is_bus) begin
          ph <= SETUP;
          tcnt <= '0;
          tmo <= 1'b0;
          bus.ADDRESS_HIGH <= 8'hE8;
          bus.ADDRESS_LOW <= idx;
          bus.BUS_RW <= !is_wr;
          bus.DATA_OUT <= wdat;
          bus.DATA_OE <= is_wr;
        end
        SETUP: begin
          ph <= STROBE;
          bus.BUS_AS <= 1'b0;
          bus.BUS_UDS <= 1'b0;
        end
        STROBE: if (!bus.DTACK || tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
          ph <= RECOV;
          bus.BUS_AS <= 1'b1;
          bus.BUS_UDS <= 1'b1;
          tmo <= bus.DTACK;
          if (!bus.DTACK && st == RD_T0) typ[7:4] <= bus.DATA_IN;
          if (!bus.DTACK && st == RD_T1) typ[3:0] <= bus.DATA_IN;
          if (!bus.DTACK && st == RD_P0) prod[7:4] <= ~bus.DATA_IN;
          if (!bus.DTACK && st == RD_P1) prod[3:0] <= ~bus.DATA_IN;
        end else tcnt <= tcnt + 16'd1;
        default: begin
          ph <= B_IDLE;
          bus.DATA_OE <= 1'b0;
          bus.BUS_RW <= 1'b1;
        end
      endcase
      case (st)
        IDLE: if (START) begin
          st <= RD_T0;
          BUSY <= 1'b1;
          TIMEOUT <= 1'b0;
          BOARD_COUNT <= '0;
          nxt <= {1'b0, BASE_FIRST};
        end
        ALLOC: begin
          st <= fits ? WR_LO : WR_SHUT;
          shut <= !fits;
          base <= fits ? aligned[7:0] : 8'h00;
          nxt <= fits ? aligned + n : nxt;
        end
        REPORT: if (BOARD_COUNT == 4'(MAX_BOARDS)) begin
          st <= FINISH;
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end else st <= RD_T0;
        FINISH: st <= IDLE;
        default: if (ph == RECOV) begin
          if (tmo || (st == RD_T1 && typ[7:6] != 2'b11)) begin
            st <= FINISH;
            DONE <= 1'b1;
            BUSY <= 1'b0;
            TIMEOUT <= tmo;
          end else if (st == WR_HI || st == WR_SHUT) begin
            st <= REPORT;
            BOARD_VALID <= 1'b1;
            BOARD_BASE <= base;
            BOARD_SIZE <= typ[2:0];
            BOARD_PRODUCT <= prod;
            BOARD_SHUTUP <= shut;
            BOARD_COUNT <= BOARD_COUNT + 4'd1;
          end else st <= st == RD_T0 ? RD_T1 : st == RD_T1 ? RD_P0 : st == RD_P0 ? RD_P1 : st == RD_P1 ? ALLOC : WR_HI;
        end
      endcase
    end
endmodule

// File: tb/tb_autoconfig_host.sv
// tb_autoconfig_host: board-chain responder plus vector table and scoreboard for autoconfig_host
module tb_autoconfig_host;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, timeout, board_valid, board_shutup;
  logic [7:0] board_base, board_product;
  logic [2:0] board_size;
  logic [3:0] board_count;
  int n_run = 0;
  int n_fail = 0;
  autoconfig_host_if bus();
  autoconfig_host dut (
    .MB_CLK(clk), .RESET(rst_n), .bus(bus), .START(start), .BUSY(busy), .DONE(done),
    .TIMEOUT(timeout), .BOARD_VALID(board_valid), .BOARD_BASE(board_base), .BOARD_SIZE(board_size),
    .BOARD_PRODUCT(board_product), .BOARD_SHUTUP(board_shutup), .BOARD_COUNT(board_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [7:0] typ; logic [7:0] prd; logic [7:0] base; logic shut;} brd_t;
  typedef struct {int first; int nb; int dly; logic to; logic [3:0] cnt;} vec_t;
  typedef struct packed {logic [6:0] idx; logic [3:0] dat;} wr_t;
  typedef struct packed {logic [7:0] base; logic [2:0] size; logic [7:0] prod; logic shut; logic [3:0] cnt;} rep_t;
  brd_t bt[10];
  vec_t vt[6];
  wr_t wq[$];
  rep_t rq[$];
  logic [7:0] ch_typ[16];
  logic [7:0] ch_prd[16];
  int ch_n = 0;
  int ch_dly = 0;
  int ch_cur = 0;
  int scnt = 0;
  function automatic logic [3:0] nibble(input logic [6:0] i, input logic [7:0] t, input logic [7:0] p);
    return i == 7'h00 ? t[7:4] : i == 7'h01 ? t[3:0] : i == 7'h02 ? ~p[7:4] : ~p[3:0];
  endfunction
  // chain responder: acks after ch_dly strobe cycles, a board leaves the chain once written at 'h24 or 'h26
  always @(negedge clk) begin
    if (!busy) ch_cur <= 0;
    if (bus.BUS_AS) begin
      scnt <= 0;
      bus.DTACK <= 1'b1;
    end else begin
      scnt <= scnt + 1;
      if (ch_cur < ch_n && scnt == ch_dly) begin
        bus.DTACK <= 1'b0;
        bus.DATA_IN <= nibble(bus.ADDRESS_LOW, ch_typ[ch_cur], ch_prd[ch_cur]);
        if (!bus.BUS_RW && (bus.ADDRESS_LOW == 7'h24 || bus.ADDRESS_LOW == 7'h26)) ch_cur <= ch_cur + 1;
      end else bus.DTACK <= 1'b1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic push_board(input logic [7:0] t, input logic [7:0] p, input logic [7:0] b, input logic s, input logic [3:0] k);
    if (s) wq.push_back({7'h26, 4'h0});
    else begin
      wq.push_back({7'h25, b[3:0]});
      wq.push_back({7'h24, b[7:4]});
    end
    rq.push_back({b, t[2:0], p, s, k});
  endtask
  task automatic run(input int budget, output int fl, output int ll, output bit ok);
    int sl = 0;
    bit got = 0;
    logic pas = 1'b1;
    wr_t w;
    rep_t r;
    fl = -1;
    ll = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    for (int c = 0; c < budget && !got; c++) begin
      if (!bus.BUS_AS) begin
        if (pas && !bus.BUS_RW) begin
          if (wq.size() == 0) chk("unexpected_write", {bus.ADDRESS_LOW, bus.DATA_OUT}, 32'hFFFF_FFFF);
          else begin
            w = wq.pop_front();
            chk("write", {bus.DATA_OE, bus.ADDRESS_HIGH, bus.ADDRESS_LOW, bus.DATA_OUT}, {1'b1, 8'hE8, w});
          end
        end
        sl++;
      end else if (!pas) begin
        if (fl < 0) fl = sl;
        ll = sl;
        sl = 0;
      end
      if (board_valid) begin
        if (rq.size() == 0) chk("unexpected_report", {board_base, board_count}, 32'hFFFF_FFFF);
        else begin
          r = rq.pop_front();
          chk("report", {board_base, board_size, board_product, board_shutup, board_count}, r);
        end
      end
      got = done;
      pas = bus.BUS_AS;
      if (!got) @(negedge clk);
    end
    ok = got;
    if (!got) chk("done_wait", 0, 1);
  endtask
  task automatic finish_checks(input string nm);
    chk({nm, "_writes_left"}, wq.size(), 0);
    chk({nm, "_reports_left"}, rq.size(), 0);
    wq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic run_vec(input int v);
    int fl, ll;
    bit ok;
    bit live = 1;
    brd_t b;
    ch_n = vt[v].nb;
    ch_dly = vt[v].dly;
    for (int i = 0; i < vt[v].nb; i++) begin
      b = bt[vt[v].first + i];
      ch_typ[i] = b.typ;
      ch_prd[i] = b.prd;
      if (b.typ[7:6] != 2'b11) live = 0;
      if (live) push_board(b.typ, b.prd, b.base, b.shut, 4'(i + 1));
    end
    run(3000, fl, ll, ok);
    if (ok) begin
      chk($sformatf("v%0d_done", v), {busy, timeout, board_count}, {1'b0, vt[v].to, vt[v].cnt});
      chk($sformatf("v%0d_cycle_len", v), fl + 2, vt[v].dly + 3);
      if (vt[v].to) chk($sformatf("v%0d_timeout_strobes", v), ll, 64);
    end
    finish_checks($sformatf("v%0d", v));
  endtask
  initial begin
    int fl, ll, sl;
    bit ok, hit, quiet;
    bt = '{
      '{8'hC5, 8'h76, 8'h20, 1'b0},
      '{8'hC4, 8'h11, 8'h20, 1'b0}, '{8'hC6, 8'h22, 8'h40, 1'b0},
      '{8'hC7, 8'hA1, 8'h20, 1'b0}, '{8'hC7, 8'hA2, 8'h60, 1'b0}, '{8'hC7, 8'hA3, 8'h00, 1'b1},
      '{8'h00, 8'h00, 8'h00, 1'b0},
      '{8'hC1, 8'h66, 8'h20, 1'b0}, '{8'hC0, 8'h55, 8'h00, 1'b1}, '{8'hC5, 8'h77, 8'h30, 1'b0}
    };
    vt = '{
      '{0, 1, 0, 1'b1, 4'd1},
      '{1, 2, 0, 1'b1, 4'd2},
      '{3, 3, 0, 1'b1, 4'd3},
      '{6, 1, 0, 1'b0, 4'd0},
      '{7, 3, 2, 1'b1, 4'd3},
      '{0, 1, 5, 1'b1, 4'd1}
    };
    repeat (3) @(negedge clk);
    chk("reset_bus", {bus.BUS_AS, bus.BUS_UDS, bus.BUS_LDS, bus.BUS_RW, bus.DATA_OE, bus.DATA_OUT, bus.ADDRESS_HIGH, bus.ADDRESS_LOW},
        {4'hF, 1'b0, 4'h0, 8'h00, 7'h00});
    chk("reset_status", {busy, done, timeout, board_valid, board_base, board_size, board_product, board_shutup, board_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    ch_n = 0;
    ch_dly = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_before_setup", {busy, bus.BUS_AS, bus.ADDRESS_HIGH}, {1'b1, 1'b1, 8'h00});
    @(negedge clk);
    chk("first_setup", {bus.BUS_AS, bus.BUS_UDS, bus.ADDRESS_HIGH, bus.ADDRESS_LOW, bus.BUS_RW, bus.DATA_OE},
        {1'b1, 1'b1, 8'hE8, 7'h00, 1'b1, 1'b0});
    @(negedge clk);
    chk("first_strobe", {bus.BUS_AS, bus.BUS_UDS, bus.BUS_LDS}, 3'b001);
    sl = 1;
    for (int c = 0; c < 200 && !bus.BUS_AS; c++) begin
      @(negedge clk);
      if (!bus.BUS_AS) sl++;
    end
    chk("no_dtack_strobes", sl, 64);
    @(negedge clk);
    chk("no_dtack_done", {done, busy, timeout, board_count}, {1'b1, 1'b0, 1'b1, 4'd0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", {busy, timeout, bus.BUS_AS}, 3'b011);
    for (int v = 0; v < 6; v++) run_vec(v);
    ch_n = 9;
    ch_dly = 0;
    for (int i = 0; i < 9; i++) begin
      ch_typ[i] = 8'hC1;
      ch_prd[i] = 8'(8'h10 + i);
    end
    for (int i = 0; i < 8; i++) push_board(8'hC1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0, 4'(i + 1));
    run(3000, fl, ll, ok);
    if (ok) chk("max_boards_done", {busy, timeout, board_count}, {1'b0, 1'b0, 4'd8});
    finish_checks("max_boards");
    ch_n = 1;
    ch_dly = 10;
    ch_typ[0] = 8'hC5;
    ch_prd[0] = 8'h76;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      hit = !bus.BUS_AS && !bus.BUS_RW && bus.ADDRESS_LOW == 7'h24;
    end
    chk("reach_wr_hi", hit, 1);
    chk("wr_hi_data", {bus.DATA_OE, bus.DATA_OUT}, {1'b1, 4'h2});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.BUS_AS, bus.BUS_UDS, busy, bus.DATA_OE}, 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.BUS_AS || bus.DATA_OE || busy || done) quiet = 0;
    end
    chk("quiet_after_reset", quiet, 1);
    run_vec(0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
